// File: rtl/bcd_gate_counter.sv
// Gated BCD event counter with display capture, leading-zero blanking and overflow flag.
// Optional: define BCD_OVF_DASH_EN to show a dash (4'hA) on every digit while overflow is set.

module bcd_gate_digit (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       clr_i,
    input  logic       set1_i,
    output logic [3:0] digit_o,
    output logic       is9_o
);
    logic [3:0] digit_q, digit_d;

    assign is9_o   = (digit_q == 4'd9);
    assign digit_o = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (clr_i)
            digit_d = set1_i ? 4'd1 : 4'd0;
        else if (inc_i)
            digit_d = is9_o ? 4'd0 : digit_q + 4'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) digit_q <= 4'd0;
        else       digit_q <= digit_d;
    end
endmodule

module bcd_gate_counter #(
    parameter int DIGITS = 8,
    parameter int SEL_W  = 3
) (
    input  logic             fpga_clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             latchit,
    input  logic             reset_ctr,
    input  logic [SEL_W-1:0] digit_select,
    output logic [3:0]       digit_muxed,
    output logic             carry_out,
    output logic             overflow
);
    logic [DIGITS-1:0][3:0] cnt;
    logic [DIGITS-1:0][3:0] disp_q;
    logic [DIGITS-1:0]      is9;
    logic [DIGITS:0]        inc;
    logic [DIGITS-1:0]      blank_q, blank_d;
    logic                   ovf_run_q, ovf_run_d;
    logic                   ovf_q;
    logic                   carry_q;
    logic                   hi_zero;
    logic [3:0]             mux_d;

    // Digit k advances only when every lower digit is rolling over from 9.
    assign inc[0] = clk_enable;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        assign inc[k+1] = inc[k] & is9[k];
        bcd_gate_digit u_dig (
            .clk_i   (fpga_clk),
            .rst_i   (reset),
            .inc_i   (inc[k]),
            .clr_i   (reset_ctr),
            .set1_i  ((k == 0) ? clk_enable : 1'b0),
            .digit_o (cnt[k]),
            .is9_o   (is9[k])
        );
    end

    assign ovf_run_d = reset_ctr ? 1'b0 : (ovf_run_q | inc[DIGITS]);

    // Digit k blanks when it and all higher digits are zero; digit 0 always shows.
    always_comb begin
        hi_zero = 1'b1;
        blank_d = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hi_zero    = hi_zero & (cnt[k] == 4'd0);
            blank_d[k] = (k != 0) && hi_zero;
        end
    end

    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            disp_q    <= '0;
            blank_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
            ovf_run_q <= 1'b0;
            ovf_q     <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            carry_q   <= inc[DIGITS];
            ovf_run_q <= ovf_run_d;
            if (latchit) begin
                disp_q  <= cnt;
                blank_q <= blank_d;
                ovf_q   <= ovf_run_q;
            end
        end
    end

    always_comb begin
        mux_d = 4'hF;
        for (int k = 0; k < DIGITS; k++) begin
            if (digit_select == SEL_W'(k)) begin
                if (!blank_q[k]) mux_d = disp_q[k];
`ifdef BCD_OVF_DASH_EN
                if (ovf_q) mux_d = 4'hA;
`endif
            end
        end
    end

    assign digit_muxed = mux_d;
    assign carry_out   = carry_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_bcd_gate_counter.sv
// Bench for bcd_gate_counter: an 8-digit and a 3-digit instance share stimulus and are
// checked every cycle against an integer-arithmetic model, plus literal spot checks.

module tb_bcd_gate_counter;
    logic       fpga_clk = 0;
    logic       reset = 0;
    logic       clk_enable = 0, latchit = 0, reset_ctr = 0;
    logic [2:0] digit_select = 0;
    logic [3:0] dm8, dm3;
    logic       co8, co3, ov8, ov3;

`ifdef BCD_OVF_DASH_EN
    localparam bit DASH = 1'b1;
`else
    localparam bit DASH = 1'b0;
`endif

    int total = 0, passed = 0;

    always #5 fpga_clk = ~fpga_clk;

    bcd_gate_counter #(.DIGITS(8), .SEL_W(3)) u8 (
        .fpga_clk(fpga_clk), .reset(reset), .clk_enable(clk_enable), .latchit(latchit),
        .reset_ctr(reset_ctr), .digit_select(digit_select),
        .digit_muxed(dm8), .carry_out(co8), .overflow(ov8));

    bcd_gate_counter #(.DIGITS(3), .SEL_W(3)) u3 (
        .fpga_clk(fpga_clk), .reset(reset), .clk_enable(clk_enable), .latchit(latchit),
        .reset_ctr(reset_ctr), .digit_select(digit_select),
        .digit_muxed(dm3), .carry_out(co3), .overflow(ov3));

    // Model: counts as plain integers, display derived by decimal division.
    int    ndig [2] = '{8, 3};
    longint cnt [2] = '{0, 0};
    longint disp[2] = '{0, 0};
    bit    ovfr [2] = '{0, 0};
    bit    ovf  [2] = '{0, 0};
    bit    carry[2] = '{0, 0};

    function automatic longint p10(int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [3:0] exp_digit(int inst, int sel);
        longint p;
        if (sel >= ndig[inst]) return 4'hF;
        if (DASH && ovf[inst]) return 4'hA;
        p = p10(sel);
        if (sel > 0 && disp[inst] < p) return 4'hF;
        return 4'((disp[inst] / p) % 10);
    endfunction

    always @(posedge fpga_clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                cnt[i] = 0; disp[i] = 0; ovfr[i] = 0; ovf[i] = 0; carry[i] = 0;
            end else begin
                bit wrap;
                wrap = clk_enable && (cnt[i] == p10(ndig[i]) - 1);
                if (latchit) begin
                    disp[i] = cnt[i];
                    ovf[i]  = ovfr[i];
                end
                carry[i] = wrap;
                if (reset_ctr) begin
                    cnt[i]  = clk_enable ? 1 : 0;
                    ovfr[i] = 0;
                end else begin
                    cnt[i]  = wrap ? 0 : cnt[i] + (clk_enable ? 1 : 0);
                    ovfr[i] = ovfr[i] | wrap;
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    always @(negedge fpga_clk) begin
        chk("u8_digit", dm8, exp_digit(0, digit_select));
        chk("u8_carry", co8, carry[0]);
        chk("u8_ovf",   ov8, ovf[0]);
        chk("u3_digit", dm3, exp_digit(1, digit_select));
        chk("u3_carry", co3, carry[1]);
        chk("u3_ovf",   ov3, ovf[1]);
    end

    task automatic cyc(bit e, bit l, bit r);
        clk_enable = e; latchit = l; reset_ctr = r;
        @(posedge fpga_clk); #1;
        clk_enable = 0; latchit = 0; reset_ctr = 0;
    endtask

    task automatic pulses(int n);
        repeat (n) cyc(1, 0, 0);
    endtask

    task automatic lit(string nm, int inst, int sel, logic [3:0] exp);
        digit_select = 3'(sel);
        #1;
        chk(nm, (inst == 0) ? dm8 : dm3, exp);
    endtask

    logic [3:0] t1_exp [8] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF};

    initial begin
        #1 reset = 1;
        repeat (3) @(posedge fpga_clk);
        #1;
        lit("rst_sel0", 0, 0, 4'h0);
        lit("rst_sel1", 0, 1, 4'hF);
        chk("rst_ovf", ov8, 1'b0);
        chk("rst_carry", co8, 1'b0);
        reset = 0;
        @(posedge fpga_clk); #1;

        // 1234 then latch then clear
        pulses(1234);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        for (int s = 0; s < 8; s++) lit("t1234_sel", 0, s, t1_exp[s]);
        chk("t1234_ovf8", ov8, 1'b0);
        chk("t1234_ovf3", ov3, 1'b1);
        cyc(0, 1, 0);
        lit("t1234_cleared_sel0", 0, 0, 4'h0);
        lit("t1234_cleared_sel1", 0, 1, 4'hF);

        // 500 with latch+enable+clear together
        pulses(500);
        cyc(1, 1, 1);
        lit("t500_sel0", 0, 0, 4'h0);
        lit("t500_sel1", 0, 1, 4'h0);
        lit("t500_sel2", 0, 2, 4'h5);
        lit("t500_sel3", 0, 3, 4'hF);
        cyc(0, 1, 0);
        lit("t500_next_sel0", 0, 0, 4'h1);
        lit("t500_next_sel1", 0, 1, 4'hF);

        // 7 with latch+enable together
        cyc(0, 0, 1);
        pulses(7);
        cyc(1, 1, 0);
        lit("t7_sel0", 0, 0, 4'h7);
        lit("t7_sel1", 0, 1, 4'hF);
        cyc(0, 1, 0);
        lit("t7_next_sel0", 0, 0, 4'h8);

        // 3-digit wrap: 999 -> 0
        cyc(0, 0, 1);
        pulses(999);
        chk("wrap_pre_carry", co3, 1'b0);
        cyc(1, 0, 0);
        chk("wrap_carry_hi", co3, 1'b1);
        chk("wrap_carry8_lo", co8, 1'b0);
        @(posedge fpga_clk); #1;
        chk("wrap_carry_lo", co3, 1'b0);
        cyc(0, 1, 0);
        chk("wrap_ovf3", ov3, 1'b1);
        chk("wrap_ovf8", ov8, 1'b0);
        lit("wrap_u3_sel0", 1, 0, DASH ? 4'hA : 4'h0);
        lit("wrap_u3_sel1", 1, 1, DASH ? 4'hA : 4'hF);
        lit("wrap_u3_sel3", 1, 3, 4'hF);
        lit("wrap_u8_sel3", 0, 3, 4'h1);
        lit("wrap_u8_sel4", 0, 4, 4'hF);

        // zero count
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        lit("zero_sel0", 0, 0, 4'h0);
        lit("zero_sel7", 0, 7, 4'hF);
        lit("zero_u3_sel7", 1, 7, 4'hF);
        chk("zero_ovf3", ov3, 1'b0);

        // async reset mid-gate
        pulses(4321);
        cyc(0, 1, 0);
        digit_select = 0;
        #1;
        chk("pre_areset_sel0", dm8, 4'h1);
        chk("pre_areset_ovf3", ov3, 1'b1);
        @(posedge fpga_clk); #2;
        reset = 1;
        #1;
        chk("areset_sel0", dm8, 4'h0);
        chk("areset_ovf8", ov8, 1'b0);
        chk("areset_carry8", co8, 1'b0);
        chk("areset_ovf3", ov3, 1'b0);
        digit_select = 1;
        #1;
        chk("areset_sel1", dm8, 4'hF);
        @(posedge fpga_clk); #1;
        reset = 0;
        pulses(3);
        cyc(0, 1, 0);
        lit("resume_sel0", 0, 0, 4'h3);
        lit("resume_sel1", 0, 1, 4'hF);

        @(posedge fpga_clk); #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
